sys_regfile_bank: RTL
=====================

# sys_regfile_bank

Parametrised register bank feeding the systolic array's operand and weight registers; the next generation of the 4×8-bit save/read register array. It adds a configurable width and depth, a registered read port with its own address, and a streaming write mode with an auto-incrementing pointer. It also provides a multi-cycle clear sweep and out-of-range write detection. The bank sits between the pin-level load interface and the processing elements.

## Interface
Parameters:
- DATA_W, 8, bits per entry
- DEPTH, 4, number of entries (≥2)
- ADDR_W, 7, external address bus width; addresses ≥ DEPTH are unmapped
- PTR_W, $clog2(DEPTH), stream pointer width (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- wr_en  in  1  write request this cycle
- wr_addr  in  ADDR_W  write address (direct mode)
- wr_data  in  DATA_W  write data
- stream_en  in  1  1: write to internal pointer, ignore wr_addr
- ptr_rst  in  1  synchronous pointer reset to 0
- clr  in  1  start clear sweep (single-cycle pulse)
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- rd_perr  out  1  registered parity error flag (see Configuration)
- ptr  out  PTR_W  current stream pointer
- busy  out  1  clear sweep in progress
- wr_err  out  1  sticky write-error flag

## Operation
- Reset (asynchronous): all entries, rd_data, rd_perr, ptr, busy and wr_err are 0; state is IDLE.
- FSM states: IDLE and CLEAR.
  - IDLE→CLEAR on clr; CLEAR→IDLE after DEPTH cycles.
  - clr while in CLEAR is ignored.
- CLEAR sweep:
  - Entry k is zeroed in sweep cycle k.
  - busy=1 throughout the sweep.
  - Sweep completion also resets ptr to 0 and clears wr_err.
- Direct write: wr_en & !stream_en & !busy & wr_addr<DEPTH writes mem[wr_addr].
- Stream write: wr_en & stream_en & !busy writes mem[ptr], then ptr increments; it wraps from DEPTH-1 to 0.
- ptr_rst sets ptr to 0. If it coincides with a stream write, the write goes to the old ptr, and ptr becomes 0 (ptr_rst wins).
- wr_err is set and held on either of:
  - a direct write with wr_addr≥DEPTH (no entry modified);
  - any wr_en while busy (write dropped).
- Read path:
  - Every cycle rd_data <= (rd_addr<DEPTH) ? mem[rd_addr] : 0.
  - The read is unconditional and unaffected by busy.
- Same-cycle read and write to one entry: rd_data returns the pre-write value (read-before-write).
- Arithmetic: ptr is modulo DEPTH, including for non-power-of-2 DEPTH. Address compares use the full ADDR_W bits and never truncate.

## Timing
- Read latency is 1. rd_addr sampled at edge N appears on rd_data after edge N.
- Write-to-read is 1 cycle. A write at edge N is visible to a read sampled at edge N+1.
- clr sampled at edge N:
  - busy=1 from edge N.
  - Entries 0..DEPTH-1 are zeroed at edges N+1..N+DEPTH.
  - busy=0 after edge N+DEPTH.
  - The first accepted write is at edge N+DEPTH+1.
- Reset asserted mid-sweep immediately returns to IDLE with all state zeroed.

## Configuration
- REGFILE_PARITY_EN defined:
  - Each entry stores an extra even-parity bit computed from wr_data at write time; the clear sweep writes parity 0.
  - rd_perr is registered alongside rd_data: 1 if the stored parity mismatches the stored data.
  - rd_perr is 0 for unmapped addresses.
- REGFILE_PARITY_EN undefined: no parity storage, and rd_perr is tied to 0.

## Test plan
- Reset, then read all addresses 0..DEPTH-1 and address 100 → rd_data=0 for each; busy=0, wr_err=0, ptr=0.
- Direct writes 0xA5→addr1 and 0x3C→addr3; read addr1, addr3 → 0xA5 then 0x3C one cycle after each rd_addr. Write 0x77→addr 9 → no entry changes and wr_err=1.
- stream_en=1 with 5 writes 0x11..0x55 (DEPTH=4) → mem={0x55,0x22,0x33,0x44} and ptr=1.
- Same-cycle write 0x99→addr2 and read addr2 (old value 0x33) → rd_data=0x33; a read of addr2 the next cycle → 0x99.
- Fill the bank, pulse clr, and assert wr_en during the sweep → busy high exactly 4 cycles; all entries 0; ptr=0; wr_err cleared at sweep end (the dropped write sets it during the sweep).
- With REGFILE_PARITY_EN, force a stored data bit flip in entry 0, then read addr0 → rd_perr=1. Without the macro → rd_perr=0 always.

Source files
------------

// File: rtl/sys_regfile_bank.sv
// Parametrised register bank with registered read, streaming writes and clear sweep.
// Optional parity storage enabled by defining REGFILE_PARITY_EN.
module sys_regfile_bank #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 7,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              stream_en,
   input  logic              ptr_rst,
   input  logic              clr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_perr,
   output logic [PTR_W-1:0]  ptr,
   output logic              busy,
   output logic              wr_err
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  cnt;

   logic             wr_in;
   logic             rd_in;
   logic             dir_we;
   logic             str_we;
   logic [PTR_W-1:0] wa;
   logic [PTR_W-1:0] ra;
   logic [PTR_W-1:0] ptr_nxt;

   // Full-width compares so high address bits never alias onto real entries
   assign wr_in   = 32'(wr_addr) < 32'(DEPTH);
   assign rd_in   = 32'(rd_addr) < 32'(DEPTH);
   assign dir_we  = wr_en & ~stream_en & ~busy & wr_in;
   assign str_we  = wr_en & stream_en & ~busy;
   assign wa      = stream_en ? ptr : wr_addr[PTR_W-1:0];
   assign ra      = rd_addr[PTR_W-1:0];
   assign ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         ptr     <= '0;
         wr_err  <= 1'b0;
         rd_data <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         rd_data <= rd_in ? mem[ra] : '0;
         if (wr_en & (busy | (~stream_en & ~wr_in))) wr_err <= 1'b1;
         if (dir_we | str_we) mem[wa] <= wr_data;
         if (str_we) ptr <= ptr_nxt;
         if (ptr_rst) ptr <= '0;
         unique case (state)
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            CLEAR: begin
               mem[cnt] <= '0;
               cnt      <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  ptr    <= '0;
                  wr_err <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef REGFILE_PARITY_EN
   logic par [DEPTH];

   // Even parity: stored bit equals XOR of the data bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_perr <= 1'b0;
         for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
      end else begin
         rd_perr <= rd_in ? (par[ra] ^ (^mem[ra])) : 1'b0;
         if (dir_we | str_we) par[wa] <= ^wr_data;
         if (state == CLEAR) par[cnt] <= 1'b0;
      end
   end
`else
   assign rd_perr = 1'b0;
`endif

endmodule
